// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII line packer.
package ascii_pkg;

  localparam int CHAR_W    = 7;
  localparam int MAX_CHARS = 146;
  localparam int MSG_W     = 1023;
  localparam int CNT_W     = 8;

  // MAX_CHARS in the width of the count register, for direct comparison.
  localparam logic [CNT_W-1:0] MAX_COUNT = 8'd146;

  localparam logic [CHAR_W-1:0] ASCII_CR  = 7'h0D;
  localparam logic [CHAR_W-1:0] ASCII_BS  = 7'h08;
  localparam logic [CHAR_W-1:0] ASCII_NUL = 7'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/ascii_slot_decoder.sv
// Turns a slot address into a one-hot slot write enable.
// Addresses at or beyond MAX_CHARS enable no slot.
module ascii_slot_decoder
  import ascii_pkg::*;
(
  input  logic [CNT_W-1:0]     count_i,
  output logic [MAX_CHARS-1:0] slot_en_o
);

  // One enable bit per slot, high only for the addressed slot.
  always_comb begin
    slot_en_o = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (count_i == CNT_W'(i)) slot_en_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_line_packer.sv
// Collects ASCII characters into a packed line with CR termination,
// backspace editing and buffer-full termination.
// The finished line is held until msg_ack.
//
// Handshakes: a character transfers on a rising edge where
// char_valid && char_ready. char_ready is high only in COLLECT, and the
// producer must hold char_data steady until it transfers. The line transfers
// on the edge where msg_valid && msg_ack. msg_ack outside HOLD is ignored.
module ascii_line_packer
  import ascii_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char_data,
  output logic              char_ready,
  output logic [MSG_W-1:0]  ascii_IN,
  output logic [CNT_W-1:0]  char_count,
  output logic              msg_valid,
  input  logic              msg_ack,
  output logic              state_dbg
);

  state_t                          state_q;
  logic [CNT_W-1:0]                count_q;
  logic [MAX_CHARS-1:0][CHAR_W-1:0] slots_q;
  logic                            msg_valid_q;

  logic                 accept;
  logic                 is_cr;
  logic                 is_bs;
  logic                 count_nz;
  logic [CNT_W-1:0]     wr_addr_d;
  logic [CHAR_W-1:0]    wr_data_d;
  logic [CNT_W-1:0]     count_inc_d;
  logic [MAX_CHARS-1:0] slot_en;

  // Decode the incoming character.
  // A backspace addresses the last stored slot and writes NUL.
  // Anything else addresses the next free slot.
  always_comb begin
    accept      = char_valid && (state_q == COLLECT);
    is_cr       = (char_data == ASCII_CR);
    is_bs       = (char_data == ASCII_BS);
    count_nz    = (count_q != '0);
    count_inc_d = count_q + 8'd1;
    wr_addr_d   = count_q;
    wr_data_d   = char_data;
    if (is_bs) begin
      wr_data_d = ASCII_NUL;
      if (count_nz) wr_addr_d = count_q - 8'd1;
    end
  end

  ascii_slot_decoder u_slot_decoder (
    .count_i   (wr_addr_d),
    .slot_en_o (slot_en)
  );

  // Line FSM: the count, the slot buffer and the registered msg_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      slots_q     <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (is_cr) begin
              // A CR on an empty line is dropped. Otherwise it ends the line.
              if (count_nz) begin
                state_q     <= HOLD;
                msg_valid_q <= 1'b1;
              end
            end else if (is_bs) begin
              if (count_nz) begin
                count_q <= count_q - 8'd1;
                for (int i = 0; i < MAX_CHARS; i++) begin
                  if (slot_en[i]) slots_q[i] <= wr_data_d;
                end
              end
            end else begin
              count_q <= count_inc_d;
              for (int i = 0; i < MAX_CHARS; i++) begin
                if (slot_en[i]) slots_q[i] <= wr_data_d;
              end
              if (count_inc_d == MAX_COUNT) begin
                state_q     <= HOLD;
                msg_valid_q <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (msg_ack) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            slots_q     <= '0;
            msg_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          count_q     <= '0;
          slots_q     <= '0;
          msg_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Slot 0 sits in the low bits. The top bit of the bus is unused.
  always_comb begin
    ascii_IN   = {1'b0, slots_q};
    char_count = count_q;
    msg_valid  = msg_valid_q;
    char_ready = (state_q == COLLECT);
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_ascii_line_packer.sv
// Bench for ascii_line_packer: directed steps plus randomized traffic
// checked against a queue-based line model.
module tb_ascii_line_packer;

  localparam int NCH = 146;
  localparam logic [6:0] CR = 7'h0D;
  localparam logic [6:0] BS = 7'h08;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  logic char_valid;
  logic [6:0] char_data;
  logic msg_ack;
  logic char_ready;
  logic [1022:0] ascii_IN;
  logic [7:0] char_count;
  logic msg_valid;
  logic state_dbg;

  always #5 clk = ~clk;

  ascii_line_packer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .ascii_IN   (ascii_IN),
    .char_count (char_count),
    .msg_valid  (msg_valid),
    .msg_ack    (msg_ack),
    .state_dbg  (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: stored characters in order, plus a line-complete flag
  logic [6:0] line_q[$];
  bit         done_m;

  task automatic model_edge();
    if (rst) begin
      line_q.delete();
      done_m = 1'b0;
    end else if (done_m) begin
      if (msg_ack) begin
        line_q.delete();
        done_m = 1'b0;
      end
    end else if (char_valid) begin
      if (char_data == CR) begin
        if (line_q.size() > 0) done_m = 1'b1;
      end else if (char_data == BS) begin
        if (line_q.size() > 0) void'(line_q.pop_back());
      end else begin
        line_q.push_back(char_data);
        if (line_q.size() == NCH) done_m = 1'b1;
      end
    end
  endtask

  function automatic logic [1022:0] model_bus();
    logic [1022:0] b;
    b = '0;
    for (int k = 0; k < line_q.size(); k++) b[7*k +: 7] = line_q[k];
    return b;
  endfunction

  // Scoreboard comparisons
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1022:0] obs, input logic [1022:0] exp);
    int k;
    total++;
    assert (obs === exp) else begin
      bad++;
      k = 0;
      while (k < NCH && obs[7*k +: 7] === exp[7*k +: 7]) k++;
      if (k < NCH)
        $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, k, obs[7*k +: 7], exp[7*k +: 7]);
      else
        $error("FAIL %s bit1022 observed=%0b expected=%0b", tag, obs[1022], exp[1022]);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(char_ready), 32'(!done_m));
    chk({tag, ".valid"}, 32'(msg_valid), 32'(done_m));
    chk({tag, ".state"}, 32'(state_dbg), 32'(done_m));
    chk({tag, ".count"}, 32'(char_count), 32'(line_q.size()));
    chk_bus({tag, ".bus"}, ascii_IN, model_bus());
  endtask

  // Driver tasks: inputs change 1 time unit after the edge, outputs are read there
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [6:0] c, input string tag);
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
    check_model(tag);
  endtask

  task automatic ack(input string tag);
    msg_ack = 1'b1;
    tick();
    msg_ack = 1'b0;
    check_model(tag);
  endtask

  logic [1022:0] exp_bus;
  int r;

  initial begin
    rst = 1'b1; char_valid = 1'b0; char_data = '0; msg_ack = 1'b0;
    done_m = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_model("reset");
    chk("reset.count", 32'(char_count), 32'd0);
    chk("reset.ready", 32'(char_ready), 32'd1);
    chk_bus("reset.bus", ascii_IN, '0);

    // "HI" then CR
    send(7'h48, "hi0");
    chk("hi0.count", 32'(char_count), 32'd1);
    send(7'h49, "hi1");
    send(CR, "hi_cr");
    chk("hi.valid", 32'(msg_valid), 32'd1);
    chk("hi.count", 32'(char_count), 32'd2);
    exp_bus = '0; exp_bus[6:0] = 7'h48; exp_bus[13:7] = 7'h49;
    chk_bus("hi.bus", ascii_IN, exp_bus);
    ack("hi_ack");
    chk("hi_ack.ready", 32'(char_ready), 32'd1);

    // "AB", BS, "C", CR
    send(7'h41, "ab0"); send(7'h42, "ab1");
    send(BS, "ab_bs");
    chk("ab_bs.count", 32'(char_count), 32'd1);
    send(7'h43, "ab_c"); send(CR, "ab_cr");
    chk("ab.count", 32'(char_count), 32'd2);
    exp_bus = '0; exp_bus[6:0] = 7'h41; exp_bus[13:7] = 7'h43;
    chk_bus("ab.bus", ascii_IN, exp_bus);
    ack("ab_ack");

    // BS and CR on an empty line are no-ops
    send(BS, "empty_bs");
    send(CR, "empty_cr");
    chk("empty.valid", 32'(msg_valid), 32'd0);
    chk("empty.ready", 32'(char_ready), 32'd1);

    // Buffer-full termination
    for (int i = 0; i < NCH; i++) begin
      send(7'h5A, "full");
      if (i == NCH - 2) chk("full.pre_valid", 32'(msg_valid), 32'd0);
    end
    chk("full.valid", 32'(msg_valid), 32'd1);
    chk("full.count", 32'(char_count), 32'd146);
    chk("full.ready", 32'(char_ready), 32'd0);
    exp_bus = '0;
    for (int k = 0; k < NCH; k++) exp_bus[7*k +: 7] = 7'h5A;
    chk_bus("full.bus", ascii_IN, exp_bus);
    chk("full.bit1022", 32'(ascii_IN[1022]), 32'd0);

    // Producer held off in HOLD, ack together with a pending character
    char_valid = 1'b1; char_data = 7'h31;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_model("hold_stall");
    end
    msg_ack = 1'b1;
    tick();
    msg_ack = 1'b0;
    check_model("hold_ack");
    chk("hold_ack.count", 32'(char_count), 32'd0);
    tick();
    char_valid = 1'b0;
    check_model("hold_take");
    chk("hold_take.count", 32'(char_count), 32'd1);
    chk("hold_take.slot0", 32'(ascii_IN[6:0]), 32'h31);
    send(CR, "hold_cr");
    ack("hold_cr_ack");

    // Reset mid-line
    send(7'h61, "mid0"); send(7'h62, "mid1"); send(7'h63, "mid2");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_model("mid_rst");
    chk_bus("mid_rst.bus", ascii_IN, '0);
    chk("mid_rst.count", 32'(char_count), 32'd0);
    chk("mid_rst.valid", 32'(msg_valid), 32'd0);
    chk("mid_rst.ready", 32'(char_ready), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      char_valid = ($urandom_range(0, 3) != 0);
      msg_ack    = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 15);
      if (r == 0)      char_data = CR;
      else if (r <= 2) char_data = BS;
      else             char_data = 7'(32'h20 + $urandom_range(0, 94));
      tick();
      check_model("rand");
    end
    rst = 1'b0; char_valid = 1'b0; msg_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
